// File: rtl/queue_info_ctrl.sv
// Per-queue occupancy table and shared free-BM counter. Looks up the target queue of
// each arriving frame, presents it to the enqueue judge, and commits accepted frames.
module queue_info_ctrl #(
    parameter int unsigned NUM_Q    = 8,
    parameter int unsigned TOTAL_BM = 1024,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        frm_valid,
    input  logic [7:0]  frm_queue,
    input  logic [10:0] frm_length,
    output logic        frm_ready,
    output logic        enqueue_busy_n,
    output logic [7:0]  queue_number,
    output logic [10:0] frame_length,
    output logic [10:0] queue_length,
    output logic [10:0] free_cache,
    input  logic        judge_ok,
    input  logic        judge_fail,
    input  logic        deq_valid,
    input  logic [2:0]  deq_queue,
    input  logic [10:0] deq_length,
    output logic [15:0] drop_cnt,
    output logic        err_underflow
);

    localparam int unsigned QW = $clog2(NUM_Q);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, PRESENT, COMMIT} state_t;

    state_t          state;
    logic [TW-1:0]   tcnt;
    logic [10:0]     occ      [NUM_Q];
    logic [10:0]     occ_next [NUM_Q];
    logic [10:0]     free_next;
    logic [10:0]     deq_base;
    logic [10:0]     deq_rel;
    logic            underflow;
    logic            commit_en;
    logic            timeout_hit;
    logic            present_drop;
    logic            drop_evt;
    logic [QW-1:0]   qidx;
    logic [QW-1:0]   didx;

    assign qidx         = queue_number[QW-1:0];
    assign didx         = deq_queue[QW-1:0];
    assign commit_en    = (state == COMMIT) && (frame_length <= free_cache);
    assign timeout_hit  = (tcnt == TW'(TIMEOUT - 1));
    assign present_drop = judge_fail || (!judge_ok && timeout_hit);
    assign drop_evt     = ((state == PRESENT) && present_drop) ||
                          ((state == COMMIT) && !commit_en);

    // Commit is folded in first so a same-cycle dequeue sees the net occupancy;
    // an underflowing release only returns what the queue actually held.
    always_comb begin
        occ_next  = occ;
        free_next = free_cache;
        underflow = 1'b0;
        deq_base  = '0;
        deq_rel   = '0;
        if (commit_en) begin
            occ_next[qidx] = occ[qidx] + frame_length;
            free_next      = free_cache - frame_length;
        end
        if (deq_valid) begin
            deq_base = occ_next[didx];
            if (deq_length > deq_base) begin
                underflow = 1'b1;
                deq_rel   = deq_base;
            end else begin
                deq_rel   = deq_length;
            end
            occ_next[didx] = deq_base - deq_rel;
            free_next      = free_next + deq_rel;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_Q; i++) occ[i] <= '0;
            free_cache    <= 11'(TOTAL_BM);
            err_underflow <= 1'b0;
        end else begin
            occ        <= occ_next;
            free_cache <= free_next;
            if (underflow) err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            frm_ready      <= 1'b1;
            enqueue_busy_n <= 1'b0;
            queue_number   <= '0;
            frame_length   <= '0;
            queue_length   <= '0;
            tcnt           <= '0;
            drop_cnt       <= '0;
        end else begin
            if (drop_evt && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (frm_valid) begin
                        queue_number <= frm_queue;
                        frame_length <= frm_length;
                        frm_ready    <= 1'b0;
                        state        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    queue_length   <= occ[qidx];
                    tcnt           <= '0;
                    enqueue_busy_n <= 1'b1;
                    state          <= PRESENT;
                end
                PRESENT: begin
                    if (present_drop) begin
                        enqueue_busy_n <= 1'b0;
                        frm_ready      <= 1'b1;
                        state          <= IDLE;
                    end else if (judge_ok) begin
                        enqueue_busy_n <= 1'b0;
                        state          <= COMMIT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                COMMIT: begin
                    frm_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_info_ctrl.sv
// Scoreboard bench for queue_info_ctrl: a queue-array reference model predicts what is
// presented to the judge and the status after each frame; a negedge monitor compares.
module tb_queue_info_ctrl;

    localparam int TOTAL   = 1024;
    localparam int TIMEOUT = 15;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        frm_valid, judge_ok, judge_fail, deq_valid;
    logic [7:0]  frm_queue;
    logic [10:0] frm_length, deq_length;
    logic [2:0]  deq_queue;
    logic        frm_ready, enqueue_busy_n, err_underflow;
    logic [7:0]  queue_number;
    logic [10:0] frame_length, queue_length, free_cache;
    logic [15:0] drop_cnt;

    queue_info_ctrl #(.NUM_Q(8), .TOTAL_BM(TOTAL), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .frm_valid(frm_valid), .frm_queue(frm_queue), .frm_length(frm_length),
        .frm_ready(frm_ready), .enqueue_busy_n(enqueue_busy_n),
        .queue_number(queue_number), .frame_length(frame_length),
        .queue_length(queue_length), .free_cache(free_cache),
        .judge_ok(judge_ok), .judge_fail(judge_fail),
        .deq_valid(deq_valid), .deq_queue(deq_queue), .deq_length(deq_length),
        .drop_cnt(drop_cnt), .err_underflow(err_underflow)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [7:0] qn; logic [10:0] fl; logic [10:0] ql; logic [10:0] fc; } pres_t;
    typedef struct { logic [10:0] fc; logic [15:0] dc; logic er; } stat_t;

    pres_t pres_q[$];
    stat_t stat_q[$];
    int    occ_m[8];
    int    drop_m = 0;
    bit    err_m  = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int free_m();
        int s = TOTAL;
        foreach (occ_m[i]) s -= occ_m[i];
        return s;
    endfunction

    function automatic void model_deq(input int d, input int l);
        if (l > occ_m[d]) begin occ_m[d] = 0; err_m = 1'b1; end
        else occ_m[d] -= l;
    endfunction

    function automatic void drop_inc();
        if (drop_m < 65535) drop_m++;
    endfunction

    task automatic tick();
        @(posedge clk_in); #1;
        deq_valid = 0; frm_valid = 0; judge_ok = 0; judge_fail = 0;
    endtask

    task automatic drive_deq(input int d, input int l);
        deq_valid = 1; deq_queue = d[2:0]; deq_length = l[10:0];
        model_deq(d, l);
    endtask

    task automatic rand_deq();
        if ($urandom_range(0, 2) == 0) drive_deq($urandom_range(0, 7), $urandom_range(0, 300));
    endtask

    task automatic push_status();
        stat_t s;
        s.fc = 11'(free_m()); s.dc = 16'(drop_m); s.er = err_m;
        stat_q.push_back(s);
    endtask

    // resp: 0 ok, 1 fail, 2 ok+fail together, 3 no response (timeout)
    task automatic run_frame(input int q, input int len, input int resp, input int d,
                             input bit rnd, input bit cdeq, input int cdq, input int cdl);
        int    qi = q % 8;
        int    bound = 0;
        pres_t e;
        while (!frm_ready && bound < 20) begin tick(); bound++; end
        check("frm_ready_wait", frm_ready, 1);
        e.qn = 8'(q); e.fl = 11'(len); e.ql = 11'(occ_m[qi]); e.fc = 11'(free_m());
        pres_q.push_back(e);
        frm_valid = 1; frm_queue = 8'(q); frm_length = 11'(len);
        tick();
        tick();
        if (resp == 3) begin
            for (int k = 0; k < TIMEOUT; k++) begin
                if (rnd) rand_deq();
                if (k == TIMEOUT - 1) check("timeout_busy_held", enqueue_busy_n, 1);
                tick();
            end
            check("timeout_busy_released", enqueue_busy_n, 0);
            drop_inc();
        end else begin
            for (int k = 0; k < d; k++) begin
                if (rnd) begin
                    rand_deq();
                    if ($urandom_range(0, 3) == 0) begin
                        frm_valid = 1; frm_queue = 8'($urandom); frm_length = 11'($urandom);
                    end
                end
                tick();
            end
            judge_ok   = (resp == 0 || resp == 2);
            judge_fail = (resp == 1 || resp == 2);
            if (rnd) rand_deq();
            tick();
            if (resp == 0) begin
                if (len > free_m()) drop_inc();
                else occ_m[qi] += len;
                if (cdeq) drive_deq(cdq, cdl);
                tick();
            end else begin
                drop_inc();
            end
        end
        push_status();
    endtask

    logic prev_busy = 1'b0;
    logic prev_ready = 1'b1;

    always @(negedge clk_in) begin
        pres_t p;
        stat_t s;
        if (rst_n) begin
            if (enqueue_busy_n && !prev_busy) begin
                if (pres_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL present_unexpected: got busy_n=1 expected no presentation at %0t", $time);
                end else begin
                    p = pres_q.pop_front();
                    check("present_queue_number", queue_number, p.qn);
                    check("present_frame_length", frame_length, p.fl);
                    check("present_queue_length", queue_length, p.ql);
                    check("present_free_cache", free_cache, p.fc);
                end
            end
            if (frm_ready && !prev_ready) begin
                if (stat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ready_unexpected: got frm_ready rise expected none at %0t", $time);
                end else begin
                    s = stat_q.pop_front();
                    check("status_free_cache", free_cache, s.fc);
                    check("status_drop_cnt", drop_cnt, s.dc);
                    check("status_err_underflow", err_underflow, s.er);
                end
            end
        end
        prev_busy  = enqueue_busy_n;
        prev_ready = frm_ready;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        foreach (occ_m[i]) occ_m[i] = 0;
        rst_n = 0; frm_valid = 0; judge_ok = 0; judge_fail = 0; deq_valid = 0;
        frm_queue = '0; frm_length = '0; deq_queue = '0; deq_length = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_frm_ready", frm_ready, 1);
        check("reset_busy_n", enqueue_busy_n, 0);
        check("reset_free_cache", free_cache, TOTAL);
        check("reset_queue_length", queue_length, 0);
        check("reset_queue_number", queue_number, 0);
        check("reset_frame_length", frame_length, 0);
        check("reset_drop_cnt", drop_cnt, 0);
        check("reset_err_underflow", err_underflow, 0);
        rst_n = 1;
        tick();

        run_frame(2, 10, 0, 1, 0, 0, 0, 0);     // ok in 2nd PRESENT cycle
        run_frame(2, 20, 1, 0, 0, 0, 0, 0);     // fail
        run_frame(5, 4, 3, 0, 0, 0, 0, 0);      // timeout
        run_frame(3, 6, 0, 0, 0, 0, 0, 0);      // occ[3] = 6
        run_frame(3, 8, 0, 0, 0, 1, 3, 5);      // commit + same-queue release
        run_frame(3, 1, 1, 2, 0, 0, 0, 0);      // probe occ[3] = 9
        run_frame(1, 4, 0, 0, 0, 0, 0, 0);      // occ[1] = 4
        drive_deq(1, 7);                        // underflow release
        tick();
        tick();
        check("underflow_flag", err_underflow, 1);
        run_frame(9, 2, 1, 0, 0, 0, 0, 0);      // index wraps to q1, expect occ 0

        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 9);
            run_frame($urandom_range(0, 255), $urandom_range(1, 300),
                      (r <= 4 || r == 8) ? 0 : (r <= 6) ? 1 : (r == 7) ? 2 : 3,
                      $urandom_range(0, 5), 1, $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 300));
            for (int k = $urandom_range(0, 2); k > 0; k--) begin rand_deq(); tick(); end
        end

        // Reset in the middle of a presentation
        begin
            pres_t e;
            e.qn = 8'd4; e.fl = 11'd7; e.ql = 11'(occ_m[4]); e.fc = 11'(free_m());
            pres_q.push_back(e);
            frm_valid = 1; frm_queue = 8'd4; frm_length = 11'd7;
            tick();
            tick();
            @(negedge clk_in);
            @(posedge clk_in); #1;
            rst_n = 0;
            #1;
            check("midreset_busy_n", enqueue_busy_n, 0);
            check("midreset_frm_ready", frm_ready, 1);
            check("midreset_free_cache", free_cache, TOTAL);
            check("midreset_drop_cnt", drop_cnt, 0);
            check("midreset_err", err_underflow, 0);
            foreach (occ_m[i]) occ_m[i] = 0;
            drop_m = 0; err_m = 0;
            stat_q.delete();
            @(negedge clk_in);
            @(posedge clk_in); #1;
            rst_n = 1;
            #1;
            check("release_frm_ready", frm_ready, 1);
            tick();
        end
        run_frame(3, 5, 0, 0, 0, 0, 0, 0);
        run_frame(3, 1, 1, 0, 0, 0, 0, 0);

        repeat (4) tick();
        check("scoreboard_present_drained", pres_q.size(), 0);
        check("scoreboard_status_drained", stat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
